tdc_pulse_gen: RTL and testbench

Stimulus transmitter for the TDC counter path: it turns queued interval commands into `start`/`stop` pulse pairs whose spacing, in `clk` cycles, is exactly the commanded interval. A counter measuring start-to-stop distance in cycles then reports that interval as its code. The block sits in front of the head/tail counters for self-test and calibration. Commands arrive through a valid/ready port into a small FIFO, and each command can be repeated a programmed number of times.

---
 rtl/tdc_pulse_gen.sv | 180 ++++++++++++++++++
 tb/tb_tdc_pulse_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tdc_pulse_gen.sv
// Start/stop pulse-pair generator for TDC self-test and calibration.
// Queued {interval, repeat} commands become exactly spaced pulse pairs.
module tdc_pulse_gen #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_interval,
  input  logic [3:0]   cmd_repeat,
  output logic         start,
  output logic         stop,
  output logic         busy,
  output logic         done,
  output logic [15:0]  pairs_sent
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP + 1);
  localparam int EW = W + 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_RUN,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  ivl_q, ivl_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [3:0]    rep_q, rep_d;
  logic [GW-1:0] gcnt_q, gcnt_d;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [15:0]   pairs_q, pairs_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [W-1:0]  head_ivl;
  logic [3:0]    head_rep;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign {head_ivl, head_rep} = mem_q[rptr_q];

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {cmd_interval, cmd_repeat};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ivl_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      gcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      pairs_q <= '0;
    end else begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      gcnt_q  <= gcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      pairs_q <= pairs_d;
    end
  end

  // The last GAP cycle may pop directly so a queued command
  // starts GAP+1 cycles after the previous stop.
  always_comb begin
    state_d = state_q;
    ivl_d   = ivl_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    gcnt_d  = gcnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en && !empty) begin
          pop     = 1'b1;
          ivl_d   = head_ivl;
          rep_d   = head_rep;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        cnt_d = ivl_q;
        if (ivl_q == '0) begin
          gcnt_d  = GW'(GAP - 1);
          state_d = S_GAP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - W'(1);
        if (cnt_q == W'(1)) begin
          gcnt_d  = GW'(GAP - 1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GW'(1);
        end else if (rep_q != '0) begin
          rep_d   = rep_q - 4'd1;
          state_d = S_FIRE;
        end else if (en && !empty) begin
          pop     = 1'b1;
          ivl_d   = head_ivl;
          rep_d   = head_rep;
          state_d = S_FIRE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered.
  always_comb begin
    start_d = (state_d == S_FIRE);
    stop_d  = (start_d && ivl_d == '0)
           || (state_d == S_RUN && cnt_d == W'(1));
    done_d  = stop_d && (rep_d == '0);
    busy_d  = (state_d != S_IDLE) || (count_d != '0);
    pairs_d = pairs_q + 16'(stop_d);
  end

  assign start      = start_q;
  assign stop       = stop_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign pairs_sent = pairs_q;

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Bench for tdc_pulse_gen: directed and random commands checked
// every cycle against a pulse-schedule model.
module tb_tdc_pulse_gen;
  localparam int W     = 6;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_interval;
  logic [3:0]   cmd_repeat;
  logic         start;
  logic         stop;
  logic         busy;
  logic         done;
  logic [15:0]  pairs_sent;

  typedef struct {
    int d;
    int r;
  } cmd_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          act_lo = 1;
  int          act_hi = 0;
  int          free_from = 0;
  bit          armed = 1'b0;
  logic [15:0] pairs_exp = '0;
  cmd_t        q[$];
  bit          start_at[int];
  bit          stop_at[int];
  bit          done_at[int];

  always #5 clk = ~clk;

  tdc_pulse_gen #(
    .W(W),
    .DEPTH(DEPTH),
    .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_interval(cmd_interval),
    .cmd_repeat(cmd_repeat),
    .start(start),
    .stop(stop),
    .busy(busy),
    .done(done),
    .pairs_sent(pairs_sent)
  );

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // A popped command is fully determined: lay out all its pairs.
  task automatic schedule(int p, cmd_t c);
    int s;
    s = 0;
    for (int k = 0; k <= c.r; k++) begin
      s = p + 1 + k * (c.d + GAP + 1);
      start_at[s] = 1'b1;
      stop_at[s + c.d] = 1'b1;
    end
    done_at[s + c.d] = 1'b1;
    act_lo = p + 1;
    act_hi = s + c.d + GAP;
    free_from = act_hi;
  endtask

  task automatic step(bit v, int d, int r, bit e, bit rs);
    bit do_pop;
    bit do_push;
    bit exp_busy;
    @(negedge clk);
    if (armed) begin
      if (stop_at.exists(cyc)) pairs_exp++;
      exp_busy = (cyc >= act_lo && cyc <= act_hi) || q.size() != 0;
      chk("start", 16'(start), 16'(start_at.exists(cyc)));
      chk("stop", 16'(stop), 16'(stop_at.exists(cyc)));
      chk("done", 16'(done), 16'(done_at.exists(cyc)));
      chk("busy", 16'(busy), 16'(exp_busy));
      chk("cmd_ready", 16'(cmd_ready), 16'(q.size() < DEPTH));
      chk("pairs_sent", pairs_sent, pairs_exp);
    end
    cmd_valid    = v;
    cmd_interval = W'(d);
    cmd_repeat   = 4'(r);
    en           = e;
    rst          = rs;
    if (!rs) begin
      q.delete();
      start_at.delete();
      stop_at.delete();
      done_at.delete();
      pairs_exp = '0;
      act_lo = 1;
      act_hi = 0;
      free_from = 0;
      armed = 1'b1;
    end else begin
      do_pop  = (cyc >= free_from) && e && q.size() != 0;
      do_push = v && q.size() < DEPTH;
      if (do_pop) schedule(cyc, q.pop_front());
      if (do_push) q.push_back('{d, r});
    end
    cyc++;
  endtask

  task automatic idle(int n, bit e);
    repeat (n) step(1'b0, 0, 0, e, 1'b1);
  endtask

  initial begin
    bit rv;
    bit re;
    bit rr;
    int rd;
    int rp;
    rst = 1'b0;
    en = 1'b0;
    cmd_valid = 1'b0;
    cmd_interval = '0;
    cmd_repeat = '0;

    step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    idle(8, 1'b1);
    step(1'b1, 5, 0, 1'b1, 1'b1);
    idle(15, 1'b1);

    step(1'b1, 0, 2, 1'b1, 1'b1);
    idle(15, 1'b1);

    for (int i = 1; i <= 5; i++) step(1'b1, i, 0, 1'b0, 1'b1);
    idle(5, 1'b0);
    idle(40, 1'b1);

    step(1'b1, 63, 15, 1'b1, 1'b1);
    idle(1100, 1'b1);

    step(1'b1, 20, 0, 1'b1, 1'b1);
    idle(4, 1'b1);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    idle(30, 1'b1);

    idle(3, 1'b1);
    force dut.pairs_q = 16'hFFFE;
    pairs_exp = 16'hFFFE;
    idle(1, 1'b1);
    release dut.pairs_q;
    step(1'b1, 0, 1, 1'b1, 1'b1);
    idle(12, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 9) < 4);
      re = ($urandom_range(0, 9) < 8);
      rr = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 15) == 0) rd = $urandom_range(0, 63);
      else rd = $urandom_range(0, 10);
      rp = $urandom_range(0, 3);
      step(rv, rd, rp, re, rr);
    end
    idle(300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
